// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_pkg
// Purpose  : Shared RTC definitions: register addresses, transfer command,
//            FSM state encodings and the BCD date validity check shared with
//            the reader/editor side.
// Revision : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    // RTC register map and transfer command
    localparam logic [7:0] c_ADDR_DIA  = 8'h24;
    localparam logic [7:0] c_ADDR_MES  = 8'h25;
    localparam logic [7:0] c_ADDR_YEAR = 8'h26;
    localparam logic [7:0] c_ADDR_CMD  = 8'hF0;
    localparam logic [7:0] c_CMD_DATA  = 8'hF2;

    // Bus phase engine states
    localparam logic [2:0] c_PH_IDLE   = 3'd0;
    localparam logic [2:0] c_PH_SETUP  = 3'd1;
    localparam logic [2:0] c_PH_STROBE = 3'd2;
    localparam logic [2:0] c_PH_HOLD   = 3'd3;
    localparam logic [2:0] c_PH_GAP    = 3'd4;

    // Sequence-level states: RUN spans all eight phases, FIN is the done cycle
    localparam logic [1:0] c_SEQ_IDLE  = 2'd0;
    localparam logic [1:0] c_SEQ_RUN   = 2'd1;
    localparam logic [1:0] c_SEQ_FIN   = 2'd2;

    // Both nibbles must be decimal digits
    function automatic logic bcd_byte_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Day 01..31 and month 01..12; month length is not checked here.
    // Range compares on BCD are numeric once both nibbles are digits.
    function automatic logic bcd_date_valid(input logic [7:0] dia,
                                            input logic [7:0] mes,
                                            input logic [7:0] year);
        return bcd_byte_ok(dia) && bcd_byte_ok(mes) && bcd_byte_ok(year) &&
               (dia != 8'h00) && (dia <= 8'h31) &&
               (mes != 8'h00) && (mes <= 8'h12);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_phase.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_phase
// Purpose  : One RTC bus phase: SETUP (1) / STROBE (T_PH) / HOLD (1) /
//            GAP (T_PH). o_ready is high when idle or in the last GAP cycle,
//            so a go in that cycle chains the next phase with no bubble.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_phase
    import rtc_pkg::*;
#(
    parameter int T_PH = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go,
    input  logic       i_sel,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic [7:0] o_ad_out,
    output logic       o_ad_oe,
    output logic       o_ad_sel,
    output logic       o_cs_n,
    output logic       o_wr_n
);

    localparam int            c_CW   = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(T_PH - 1);

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_sel;
    logic [7:0]      r_byte;
    logic            w_load;
    logic            w_drive;

    // Ready to accept a new phase: idle, or finishing the gap of this one
    always_comb begin
        o_ready = (r_state == c_PH_IDLE) ||
                  ((r_state == c_PH_GAP) && (r_cnt == c_LAST));
    end

    assign w_load = i_go && o_ready;

    // Phase sequencing; address/data byte is captured only when entering SETUP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_PH_IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_byte  <= 8'h00;
        end else if (w_load) begin
            r_state <= c_PH_SETUP;
            r_cnt   <= '0;
            r_sel   <= i_sel;
            r_byte  <= i_byte;
        end else begin
            case (r_state)
                c_PH_SETUP: begin
                    r_state <= c_PH_STROBE;
                    r_cnt   <= '0;
                end
                c_PH_STROBE: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_PH_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_PH_HOLD: begin
                    r_state <= c_PH_GAP;
                    r_cnt   <= '0;
                end
                c_PH_GAP: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_PH_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_PH_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Bus is driven from SETUP through HOLD; released and zeroed in GAP/IDLE
    assign w_drive  = (r_state == c_PH_SETUP) || (r_state == c_PH_STROBE) ||
                      (r_state == c_PH_HOLD);
    assign o_cs_n   = ~w_drive;
    assign o_wr_n   = (r_state != c_PH_STROBE);
    assign o_ad_oe  = w_drive;
    assign o_ad_sel = w_drive & r_sel;
    assign o_ad_out = w_drive ? r_byte : 8'h00;

endmodule
`default_nettype wire

// File: rtl/rtc_fecha_writer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_fecha_writer
// Purpose  : Commits an edited BCD date to the RTC as four write
//            transactions (day, month, year, transfer command), each an
//            address phase followed by a data phase.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_fecha_writer
    import rtc_pkg::*;
#(
    parameter int         T_PH      = 4,
    parameter logic [7:0] ADDR_DIA  = c_ADDR_DIA,
    parameter logic [7:0] ADDR_MES  = c_ADDR_MES,
    parameter logic [7:0] ADDR_YEAR = c_ADDR_YEAR,
    parameter logic [7:0] ADDR_CMD  = c_ADDR_CMD,
    parameter logic [7:0] CMD_DATA  = c_CMD_DATA
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] diaC,
    input  logic [7:0] mesC,
    input  logic [7:0] yearC,
    input  logic       start,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [1:0] r_seq;
    logic [2:0] r_phase;
    logic [7:0] r_dia;
    logic [7:0] r_mes;
    logic [7:0] r_year;
    logic       r_err;

    logic       w_accept;
    logic       w_date_ok;
    logic       w_ready;
    logic       w_last;
    logic       w_go;
    logic [2:0] w_next_idx;
    logic [7:0] w_byte;

    assign w_accept  = (r_seq == c_SEQ_IDLE) && start;
    assign w_date_ok = bcd_date_valid(diaC, mesC, yearC);
    assign w_last    = (r_phase == 3'd7);

    // Launch phase 0 on a valid commit, then chain phases 1..7 as the engine frees up
    always_comb begin
        w_go       = 1'b0;
        w_next_idx = 3'd0;
        if (r_seq == c_SEQ_IDLE) begin
            w_go       = w_accept && w_date_ok;
            w_next_idx = 3'd0;
        end else if (r_seq == c_SEQ_RUN) begin
            w_go       = w_ready && !w_last;
            w_next_idx = r_phase + 3'd1;
        end
    end

    // Even phase index carries the register address, odd carries its data
    always_comb begin
        w_byte = 8'h00;
        case (w_next_idx)
            3'd0: w_byte = ADDR_DIA;
            3'd1: w_byte = r_dia;
            3'd2: w_byte = ADDR_MES;
            3'd3: w_byte = r_mes;
            3'd4: w_byte = ADDR_YEAR;
            3'd5: w_byte = r_year;
            3'd6: w_byte = ADDR_CMD;
            3'd7: w_byte = CMD_DATA;
            default: w_byte = 8'h00;
        endcase
    end

    // Sequence control: snapshot on accept, phase index, FIN done cycle, err pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq   <= c_SEQ_IDLE;
            r_phase <= 3'd0;
            r_dia   <= 8'h00;
            r_mes   <= 8'h00;
            r_year  <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && !w_date_ok;
            case (r_seq)
                c_SEQ_IDLE: begin
                    if (w_accept && w_date_ok) begin
                        r_seq   <= c_SEQ_RUN;
                        r_phase <= 3'd0;
                        r_dia   <= diaC;
                        r_mes   <= mesC;
                        r_year  <= yearC;
                    end
                end
                c_SEQ_RUN: begin
                    if (w_ready) begin
                        if (w_last) begin
                            r_seq <= c_SEQ_FIN;
                        end else begin
                            r_phase <= w_next_idx;
                        end
                    end
                end
                c_SEQ_FIN: r_seq <= c_SEQ_IDLE;
                default:   r_seq <= c_SEQ_IDLE;
            endcase
        end
    end

    rtc_bus_phase #(
        .T_PH     (T_PH)
    ) u_phase (
        .clk      (clk),
        .rst      (reset),
        .i_go     (w_go),
        .i_sel    (~w_next_idx[0]),
        .i_byte   (w_byte),
        .o_ready  (w_ready),
        .o_ad_out (ad_out),
        .o_ad_oe  (ad_oe),
        .o_ad_sel (ad_sel),
        .o_cs_n   (cs_n),
        .o_wr_n   (wr_n)
    );

    assign rd_n = 1'b1;
    assign busy = (r_seq == c_SEQ_RUN);
    assign done = (r_seq == c_SEQ_FIN);
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_fecha_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_fecha_writer
// Purpose  : Directed bench for rtc_fecha_writer at T_PH = 2, 1 and 7.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_fecha_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] diaC, mesC, yearC;
    logic       st_a, st_b, st_c;

    logic [7:0] ad_out_a, ad_out_b, ad_out_c;
    logic       ad_oe_a, ad_oe_b, ad_oe_c;
    logic       ad_sel_a, ad_sel_b, ad_sel_c;
    logic       cs_n_a, cs_n_b, cs_n_c;
    logic       wr_n_a, wr_n_b, wr_n_c;
    logic       rd_n_a, rd_n_b, rd_n_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       err_a, err_b, err_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rtc_fecha_writer #(.T_PH(2)) dut_a (
        .clk(clk), .reset(reset), .diaC(diaC), .mesC(mesC), .yearC(yearC), .start(st_a),
        .ad_out(ad_out_a), .ad_oe(ad_oe_a), .ad_sel(ad_sel_a), .cs_n(cs_n_a), .wr_n(wr_n_a),
        .rd_n(rd_n_a), .busy(busy_a), .done(done_a), .err(err_a));

    rtc_fecha_writer #(.T_PH(1)) dut_b (
        .clk(clk), .reset(reset), .diaC(diaC), .mesC(mesC), .yearC(yearC), .start(st_b),
        .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ad_sel(ad_sel_b), .cs_n(cs_n_b), .wr_n(wr_n_b),
        .rd_n(rd_n_b), .busy(busy_b), .done(done_b), .err(err_b));

    rtc_fecha_writer #(.T_PH(7)) dut_c (
        .clk(clk), .reset(reset), .diaC(diaC), .mesC(mesC), .yearC(yearC), .start(st_c),
        .ad_out(ad_out_c), .ad_oe(ad_oe_c), .ad_sel(ad_sel_c), .cs_n(cs_n_c), .wr_n(wr_n_c),
        .rd_n(rd_n_c), .busy(busy_c), .done(done_c), .err(err_c));

    // Monitored DUT selection
    int         mon_sel = 0;
    logic [7:0] m_ad;
    logic       m_oe, m_sel, m_cs_n, m_wr_n, m_busy, m_done;

    always_comb begin
        m_ad = ad_out_a; m_oe = ad_oe_a; m_sel = ad_sel_a; m_cs_n = cs_n_a;
        m_wr_n = wr_n_a; m_busy = busy_a; m_done = done_a;
        if (mon_sel == 1) begin
            m_ad = ad_out_b; m_oe = ad_oe_b; m_sel = ad_sel_b; m_cs_n = cs_n_b;
            m_wr_n = wr_n_b; m_busy = busy_b; m_done = done_b;
        end else if (mon_sel == 2) begin
            m_ad = ad_out_c; m_oe = ad_oe_c; m_sel = ad_sel_c; m_cs_n = cs_n_c;
            m_wr_n = wr_n_c; m_busy = busy_c; m_done = done_c;
        end
    end

    // Bus monitor results
    logic [7:0] cap_addr [4];
    logic [7:0] cap_data [4];
    int cap_na, cap_nd, cap_busy, cap_done, cap_smin, cap_smax, cap_unstable, cap_oe_bad;

    task automatic set_start(input int sel, input logic v);
        if (sel == 1)      st_b = v;
        else if (sel == 2) st_c = v;
        else               st_a = v;
    endtask

    // Follows one sequence from the cycle after the accepting edge to the done cycle.
    // The day input is overwritten at sample 5 to probe the snapshot.
    task automatic capture(input int sel, input logic hold, input logic [7:0] late_dia);
        logic       prev_wr;
        logic [7:0] held;
        logic       held_sel;
        int         slen;
        bit         fin;
        mon_sel = sel;
        cap_na = 0; cap_nd = 0; cap_busy = 0; cap_done = 0;
        cap_smin = 1000; cap_smax = 0; cap_unstable = 0; cap_oe_bad = 0;
        prev_wr = 1'b1; held = 8'h00; held_sel = 1'b0; slen = 0; fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            if (m_busy) cap_busy++;
            if (m_done) begin cap_done++; fin = 1'b1; end
            if (!m_wr_n) begin
                if (!m_oe) cap_oe_bad++;
                if (prev_wr) begin
                    held = m_ad; held_sel = m_sel; slen = 1;
                    if (m_sel) begin if (cap_na < 4) cap_addr[cap_na] = m_ad; cap_na++; end
                    else       begin if (cap_nd < 4) cap_data[cap_nd] = m_ad; cap_nd++; end
                end else begin
                    slen++;
                    if (m_ad !== held || m_sel !== held_sel) cap_unstable++;
                end
            end else if (!prev_wr) begin
                if (slen < cap_smin) cap_smin = slen;
                if (slen > cap_smax) cap_smax = slen;
            end
            prev_wr = m_wr_n;
            set_start(sel, hold);
            if (i == 5) diaC = late_dia;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (ad_out_a !== 8'h00) begin miscompares++; $display("FAIL reset_ad_out: got %h want 00", ad_out_a); end
        vectors++; if ({ad_oe_a, ad_sel_a} !== 2'b00) begin miscompares++; $display("FAIL reset_oe_sel: got %b want 00", {ad_oe_a, ad_sel_a}); end
        vectors++; if ({cs_n_a, wr_n_a, rd_n_a} !== 3'b111) begin miscompares++; $display("FAIL reset_strobes: got %b want 111", {cs_n_a, wr_n_a, rd_n_a}); end
        vectors++; if ({busy_a, done_a, err_a} !== 3'b000) begin miscompares++; $display("FAIL reset_status: got %b want 000", {busy_a, done_a, err_a}); end
        vectors++; if ({cs_n_b, cs_n_c, busy_b, busy_c, ad_oe_b, ad_oe_c} !== 6'b110000) begin
            miscompares++; $display("FAIL reset_other_tph: got %b want 110000", {cs_n_b, cs_n_c, busy_b, busy_c, ad_oe_b, ad_oe_c}); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n_a !== 1'b1 || rd_n_a !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_cs_rd: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_sequence();
        logic [7:0] ea [4];
        logic [7:0] ed [4];
        ea = '{8'h24, 8'h25, 8'h26, 8'hF0};
        ed = '{8'h15, 8'h03, 8'h16, 8'hF2};
        diaC = 8'h15; mesC = 8'h03; yearC = 8'h16; st_a = 1'b1;
        capture(0, 1'b0, 8'h15);
        vectors++; if (cap_na !== 4 || cap_nd !== 4) begin miscompares++; $display("FAIL seq_write_count: got %0d/%0d want 4/4", cap_na, cap_nd); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (cap_addr[k] !== ea[k]) begin miscompares++; $display("FAIL seq_addr%0d: got %h want %h", k, cap_addr[k], ea[k]); end
            vectors++; if (cap_data[k] !== ed[k]) begin miscompares++; $display("FAIL seq_data%0d: got %h want %h", k, cap_data[k], ed[k]); end
        end
        vectors++; if (cap_busy !== 48) begin miscompares++; $display("FAIL seq_busy_len: got %0d want 48", cap_busy); end
        vectors++; if (cap_done !== 1) begin miscompares++; $display("FAIL seq_done: got %0d want 1", cap_done); end
        vectors++; if (cap_smin !== 2 || cap_smax !== 2) begin miscompares++; $display("FAIL seq_strobe_len: got %0d..%0d want 2..2", cap_smin, cap_smax); end
        vectors++; if (cap_unstable !== 0 || cap_oe_bad !== 0) begin miscompares++; $display("FAIL seq_bus_stable: got %0d/%0d want 0/0", cap_unstable, cap_oe_bad); end
        @(negedge clk);
        vectors++; if ({done_a, busy_a, cs_n_a} !== 3'b001) begin miscompares++; $display("FAIL seq_after_done: got %b want 001", {done_a, busy_a, cs_n_a}); end
    endtask

    task automatic test_invalid();
        logic [23:0] vec [4];
        int cs_low;
        vec = '{24'h15_13_16, 24'h00_03_16, 24'h1A_03_16, 24'h15_03_9F};
        for (int v = 0; v < 4; v++) begin
            {diaC, mesC, yearC} = vec[v];
            st_a = 1'b1;
            cs_low = 0;
            @(negedge clk);
            st_a = 1'b0;
            vectors++; if ({err_a, busy_a} !== 2'b10) begin miscompares++; $display("FAIL invalid%0d_err: got %b want 10", v, {err_a, busy_a}); end
            if (cs_n_a !== 1'b1) cs_low++;
            @(negedge clk);
            vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL invalid%0d_err_pulse: got %b want 0", v, err_a); end
            for (int i = 0; i < 4; i++) begin
                if (cs_n_a !== 1'b1) cs_low++;
                @(negedge clk);
            end
            vectors++; if (cs_low !== 0) begin miscompares++; $display("FAIL invalid%0d_cs: got %0d low cycles want 0", v, cs_low); end
        end
    endtask

    task automatic test_back_to_back();
        diaC = 8'h15; mesC = 8'h03; yearC = 8'h16; st_a = 1'b1;
        capture(0, 1'b1, 8'h22);
        vectors++; if (cap_busy !== 48 || cap_na !== 4) begin miscompares++; $display("FAIL held_single_seq: got busy %0d writes %0d want 48/4", cap_busy, cap_na); end
        vectors++; if (cap_data[0] !== 8'h15) begin miscompares++; $display("FAIL held_snapshot_day: got %h want 15", cap_data[0]); end
        // start is still high through the FIN cycle; it must not have been taken
        @(negedge clk);
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL fin_start_ignored: got busy %b want 0", busy_a); end
        capture(0, 1'b0, 8'h22);
        vectors++; if (cap_busy !== 48 || cap_done !== 1) begin miscompares++; $display("FAIL restart_seq: got busy %0d done %0d want 48/1", cap_busy, cap_done); end
        vectors++; if (cap_data[0] !== 8'h22) begin miscompares++; $display("FAIL restart_day: got %h want 22", cap_data[0]); end
        st_a = 1'b0;
        diaC = 8'h15;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        diaC = 8'h15; mesC = 8'h03; yearC = 8'h16; st_a = 1'b1;
        // sample 31 after acceptance is the first STROBE cycle of the year data phase
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            st_a = 1'b0;
        end
        vectors++; if ({wr_n_a, ad_sel_a, ad_out_a} !== {1'b0, 1'b0, 8'h16}) begin
            miscompares++; $display("FAIL mid_year_strobe: got %b %b %h want 0 0 16", wr_n_a, ad_sel_a, ad_out_a); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({cs_n_a, wr_n_a, ad_oe_a, busy_a, done_a} !== 5'b11000) begin
            miscompares++; $display("FAIL mid_reset_release: got %b want 11000", {cs_n_a, wr_n_a, ad_oe_a, busy_a, done_a}); end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || cs_n_a !== 1'b1) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", dones); end
        st_a = 1'b1;
        capture(0, 1'b0, 8'h15);
        vectors++; if (cap_busy !== 48 || cap_done !== 1 || cap_nd !== 4) begin
            miscompares++; $display("FAIL post_reset_seq: got busy %0d done %0d data %0d want 48/1/4", cap_busy, cap_done, cap_nd); end
        vectors++; if (cap_data[2] !== 8'h16 || cap_addr[3] !== 8'hF0) begin
            miscompares++; $display("FAIL post_reset_bytes: got %h %h want 16 F0", cap_data[2], cap_addr[3]); end
        @(negedge clk);
    endtask

    task automatic test_tph(input int sel, input int exp_busy, input int exp_strobe);
        diaC = 8'h31; mesC = 8'h12; yearC = 8'h99;
        set_start(sel, 1'b1);
        capture(sel, 1'b0, 8'h31);
        vectors++; if (cap_busy !== exp_busy) begin miscompares++; $display("FAIL tph_busy_sel%0d: got %0d want %0d", sel, cap_busy, exp_busy); end
        vectors++; if (cap_smin !== exp_strobe || cap_smax !== exp_strobe) begin
            miscompares++; $display("FAIL tph_strobe_sel%0d: got %0d..%0d want %0d", sel, cap_smin, cap_smax, exp_strobe); end
        vectors++; if (cap_unstable !== 0 || cap_oe_bad !== 0 || cap_done !== 1) begin
            miscompares++; $display("FAIL tph_stable_sel%0d: got %0d/%0d/%0d want 0/0/1", sel, cap_unstable, cap_oe_bad, cap_done); end
        vectors++; if (cap_data[0] !== 8'h31 || cap_data[1] !== 8'h12 || cap_data[2] !== 8'h99 || cap_data[3] !== 8'hF2) begin
            miscompares++; $display("FAIL tph_data_sel%0d: got %h %h %h %h want 31 12 99 F2", sel, cap_data[0], cap_data[1], cap_data[2], cap_data[3]); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        diaC = 8'h15; mesC = 8'h03; yearC = 8'h16;
        test_reset();
        test_sequence();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_tph(1, 32, 1);
        test_tph(2, 128, 7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
